osf_channel_arbiter: RTL and testbench

Round-robin arbiter that shares the single PID datapath between N oversample filter channels. Each channel's filtered word, qualified by its data valid pulse, is captured in a one-deep holding slot. The arbiter grants one pending, activated channel at a time, presents that word and its channel index to the PID core, and waits for the core's done pulse before issuing the next grant. It sits between the bank of oversample filters and the PID core, and reports overwritten samples and stalled transactions to the frontpanel.

---
 rtl/osf_channel_arbiter.sv | 159 +++++++++++++++
 tb/tb_osf_channel_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osf_channel_arbiter.sv
// Round-robin arbiter that shares one PID datapath between N oversample filter channels.
// Each channel captures its latest word in a one-deep slot. One eligible channel is issued
// at a time, and the next grant waits for the PID done pulse or a wait timeout.
module osf_channel_arbiter #(
  parameter int unsigned N_CHAN  = 8,
  parameter int unsigned W_CHAN  = 3,
  parameter int unsigned W_DATA  = 18,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [N_CHAN*W_DATA-1:0]   data_in,
  input  logic [N_CHAN-1:0]          data_valid_in,
  input  logic [N_CHAN-1:0]          activate_in,
  input  logic                       pid_done_in,
  input  logic                       clear_flags_in,
  output logic signed [W_DATA-1:0]   data_out,
  output logic [W_CHAN-1:0]          chan_out,
  output logic                       data_valid_out,
  output logic                       busy_out,
  output logic [N_CHAN-1:0]          overwrite_out,
  output logic                       timeout_out
);

  localparam int unsigned     W_CNT    = 16;
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [W_DATA-1:0]         r_slot [N_CHAN];
  logic [N_CHAN-1:0]         r_pending;
  logic [W_CHAN-1:0]         r_last_grant;
  logic [W_CNT-1:0]          r_wait_cnt;
  logic signed [W_DATA-1:0]  r_data;
  logic [W_CHAN-1:0]         r_chan;
  logic                      r_valid;
  logic                      r_busy;
  logic [N_CHAN-1:0]         r_overwrite;
  logic                      r_timeout;

  logic [N_CHAN-1:0]         w_eligible;
  logic [N_CHAN-1:0]         w_grant_onehot;
  logic [N_CHAN-1:0]         w_ovf_evt;
  logic [W_CHAN-1:0]         w_grant;
  logic                      w_found;
  logic                      w_issue;
  logic                      w_timeout_evt;
  int unsigned               w_idx;

  assign w_eligible = r_pending & activate_in;
  assign w_issue    = (r_state == ST_IDLE) && w_found;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned off = 1; off <= N_CHAN; off++) begin
      w_idx = (32'(r_last_grant) + off) % N_CHAN;
      if (!w_found && w_eligible[W_CHAN'(w_idx)]) begin
        w_found = 1'b1;
        w_grant = W_CHAN'(w_idx);
      end
    end
  end

  // One-hot grant and per-channel overwrite events (a granted slot may be reloaded freely)
  always_comb begin
    w_grant_onehot = '0;
    if (w_issue) begin
      w_grant_onehot = N_CHAN'(1) << w_grant;
    end
    w_ovf_evt = activate_in & data_valid_in & r_pending & ~w_grant_onehot;
  end

  // Next-state logic; done takes priority over the timeout abort
  always_comb begin
    w_next_state  = r_state;
    w_timeout_evt = 1'b0;
    case (r_state)
      ST_IDLE: if (w_found) w_next_state = ST_SEND;
      ST_SEND: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (pid_done_in) begin
          w_next_state = ST_IDLE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_timeout_evt = 1'b1;
          w_next_state  = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!reset_in) r_state <= ST_IDLE;
    else           r_state <= w_next_state;
  end

  // Issue path, wait counter, registered strobes and the sticky timeout flag
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_data       <= '0;
      r_chan       <= '0;
      r_last_grant <= W_CHAN'(N_CHAN - 1);
      r_wait_cnt   <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_data       <= r_slot[w_grant];
        r_chan       <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == ST_SEND)      r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + W_CNT'(1);
      r_valid   <= (w_next_state == ST_SEND);
      r_busy    <= (w_next_state != ST_IDLE);
      r_timeout <= (r_timeout & ~clear_flags_in) | w_timeout_evt;
    end
  end

  // Per-channel holding slots, pending bits and sticky overwrite flags
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      for (int i = 0; i < N_CHAN; i++) r_slot[i] <= '0;
      r_pending   <= '0;
      r_overwrite <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (!activate_in[i]) begin
          r_pending[i] <= 1'b0;
        end else if (data_valid_in[i]) begin
          r_slot[i]    <= data_in[i*W_DATA +: W_DATA];
          r_pending[i] <= 1'b1;
        end else if (w_grant_onehot[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
      r_overwrite <= (r_overwrite & ~{N_CHAN{clear_flags_in}}) | w_ovf_evt;
    end
  end

  assign data_out       = r_data;
  assign chan_out       = r_chan;
  assign data_valid_out = r_valid;
  assign busy_out       = r_busy;
  assign overwrite_out  = r_overwrite;
  assign timeout_out    = r_timeout;

endmodule

// File: tb/tb_osf_channel_arbiter.sv
// Self-checking bench for osf_channel_arbiter: a cycle reference model checked on every
// cycle, a vector table for the basic issue, directed corner sequences and a random run.
module tb_osf_channel_arbiter;

  localparam int N  = 8;
  localparam int WC = 3;
  localparam int WD = 18;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N*WD-1:0]      data_in;
  logic [N-1:0]         dv;
  logic [N-1:0]         act;
  logic                 done;
  logic                 clr;
  logic signed [WD-1:0] data_out;
  logic [WC-1:0]        chan_out;
  logic                 dv_out;
  logic                 busy_out;
  logic [N-1:0]         ovf_out;
  logic                 to_out;
  logic [WD-1:0]        dout_u;

  int n_checks = 0;
  int n_err    = 0;

  assign dout_u = data_out;

  osf_channel_arbiter #(.N_CHAN(N), .W_CHAN(WC), .W_DATA(WD), .TIMEOUT(TO)) dut (
    .clk_in(clk), .reset_in(rst_n), .data_in(data_in), .data_valid_in(dv),
    .activate_in(act), .pid_done_in(done), .clear_flags_in(clr),
    .data_out(data_out), .chan_out(chan_out), .data_valid_out(dv_out),
    .busy_out(busy_out), .overwrite_out(ovf_out), .timeout_out(to_out)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs after each edge, derived from the arbiter rules
  logic [WD-1:0] m_slot [N];
  logic [N-1:0]  m_pend;
  int            m_last;
  int            m_phase;   // 0 idle, 1 issuing, 2 waiting for done
  int            m_waited;
  logic [WD-1:0] e_data;
  logic [WC-1:0] e_chan;
  logic          e_valid, e_busy, e_to;
  logic [N-1:0]  e_ovf;

  always @(posedge clk) begin : ref_model
    int g;
    bit found, grant, toe;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_slot[i] = '0;
      m_pend = '0; m_last = N - 1; m_phase = 0; m_waited = 0;
      e_data = '0; e_chan = '0; e_valid = 1'b0; e_busy = 1'b0; e_ovf = '0; e_to = 1'b0;
    end else begin
      found = 1'b0; g = 0; toe = 1'b0;
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_last + off) % N;
        if (!found && m_pend[c] && act[c]) begin found = 1'b1; g = c; end
      end
      grant = (m_phase == 0) && found;
      case (m_phase)
        0: if (found) begin
             e_data = m_slot[g]; e_chan = WC'(g); m_last = g; m_phase = 1;
           end
        1: begin m_phase = 2; m_waited = 0; end
        default: begin
          if (done) m_phase = 0;
          else if (m_waited == TO - 1) begin toe = 1'b1; m_phase = 0; end
          else m_waited++;
        end
      endcase
      e_valid = (m_phase == 1);
      e_busy  = (m_phase != 0);
      if (clr) begin e_ovf = '0; e_to = 1'b0; end
      if (toe) e_to = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!act[i]) m_pend[i] = 1'b0;
        else if (dv[i]) begin
          if (m_pend[i] && !(grant && g == i)) e_ovf[i] = 1'b1;
          m_slot[i] = data_in[i*WD +: WD];
          m_pend[i] = 1'b1;
        end else if (grant && g == i) m_pend[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Advance one edge and compare every output with the model on the falling edge
  task automatic step();
    @(negedge clk);
    chk("m_data",  64'(dout_u),   64'(e_data));
    chk("m_chan",  64'(chan_out), 64'(e_chan));
    chk("m_valid", 64'(dv_out),   64'(e_valid));
    chk("m_busy",  64'(busy_out), 64'(e_busy));
    chk("m_ovf",   64'(ovf_out),  64'(e_ovf));
    chk("m_to",    64'(to_out),   64'(e_to));
  endtask

  task automatic set_word(input int ch, input logic [WD-1:0] v);
    data_in[ch*WD +: WD] = v;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    dv = m; step(); dv = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dv = '0; done = 1'b0; clr = 1'b0; act = '1; data_in = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Step until an issue strobe is seen (bounded), then check its channel and word
  task automatic wait_issue(input string nm, input int ch, input logic [WD-1:0] d);
    step();
    for (int k = 0; k < 40 && dv_out !== 1'b1; k++) step();
    chk({nm, "_seen"}, 64'(dv_out),   64'(1));
    chk({nm, "_chan"}, 64'(chan_out), 64'(ch));
    chk({nm, "_data"}, 64'(dout_u),   64'(d));
  endtask

  task automatic finish_txn(input int lat);
    repeat (lat - 1) step();
    done = 1'b1; step(); done = 1'b0;
  endtask

  typedef struct {
    logic          dv3;
    logic          done;
    logic          ev;
    logic [WC-1:0] ec;
    logic [WD-1:0] ed;
    logic          eb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nv;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 18'h00000, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 3'd3, 18'h1F00A, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 3'd3, 18'h1F00A, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 3'd3, 18'h1F00A, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 3'd3, 18'h1F00A, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 3'd3, 18'h1F00A, 1'b0};

    // Reset state
    do_reset();
    chk("rst_data",  64'(dout_u),   64'(0));
    chk("rst_chan",  64'(chan_out), 64'(0));
    chk("rst_valid", 64'(dv_out),   64'(0));
    chk("rst_busy",  64'(busy_out), 64'(0));
    chk("rst_ovf",   64'(ovf_out),  64'(0));
    chk("rst_to",    64'(to_out),   64'(0));

    // Single channel-3 issue from the vector table
    set_word(3, 18'h1F00A);
    for (int i = 0; i < 6; i++) begin
      dv = tbl[i].dv3 ? 8'h08 : 8'h00;
      done = tbl[i].done;
      step();
      chk("t1_valid", 64'(dv_out),   64'(tbl[i].ev));
      chk("t1_chan",  64'(chan_out), 64'(tbl[i].ec));
      chk("t1_data",  64'(dout_u),   64'(tbl[i].ed));
      chk("t1_busy",  64'(busy_out), 64'(tbl[i].eb));
    end
    dv = '0; done = 1'b0;

    // Round-robin order 0,2,7 then a re-armed channel 0 waits behind 2 and 7
    do_reset();
    set_word(0, 18'h00111); set_word(2, 18'h00222); set_word(7, 18'h00777);
    pulse(8'h85);
    wait_issue("t2_g0", 0, 18'h00111);
    set_word(0, 18'h00AAA);
    step();
    pulse(8'h01);
    step();
    done = 1'b1; step(); done = 1'b0;
    wait_issue("t2_g2", 2, 18'h00222);
    finish_txn(4);
    wait_issue("t2_g7", 7, 18'h00777);
    finish_txn(4);
    wait_issue("t2_g0b", 0, 18'h00AAA);
    finish_txn(4);
    chk("t2_ovf", 64'(ovf_out), 64'(0));

    // Overwrite on channel 5 while the core is stalled, then clear
    do_reset();
    set_word(1, 18'h00001);
    pulse(8'h02);
    wait_issue("t3_g1", 1, 18'h00001);
    set_word(5, 18'h00010); pulse(8'h20);
    set_word(5, 18'h3FFF0); pulse(8'h20);
    chk("t3_ovf_set", 64'(ovf_out), 64'(8'h20));
    finish_txn(1);
    wait_issue("t3_g5", 5, 18'h3FFF0);
    finish_txn(2);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_ovf_clr", 64'(ovf_out), 64'(0));

    // Deactivation while pending drops the sample; during wait the transaction completes
    do_reset();
    set_word(0, 18'h00005);
    pulse(8'h01);
    wait_issue("t4_g0", 0, 18'h00005);
    pulse(8'h02);
    act = 8'hFD; step();
    finish_txn(2);
    nv = 0;
    repeat (10) begin step(); if (dv_out === 1'b1) nv++; end
    act = 8'hFF;
    repeat (3) begin step(); if (dv_out === 1'b1) nv++; end
    chk("t4_no_grant", 64'(nv), 64'(0));
    set_word(1, 18'h01234);
    pulse(8'h02);
    wait_issue("t4_g1", 1, 18'h01234);
    act = 8'hFD; step(); step();
    chk("t4_busy_wait", 64'(busy_out), 64'(1));
    done = 1'b1; step(); done = 1'b0;
    chk("t4_busy_done", 64'(busy_out), 64'(0));
    chk("t4_chan_hold", 64'(chan_out), 64'(1));
    act = 8'hFF;

    // Timeout abort TO cycles after entering wait, then the next pending channel issues
    do_reset();
    set_word(2, 18'h00002); set_word(4, 18'h00004);
    pulse(8'h14);
    wait_issue("t5_g2", 2, 18'h00002);
    for (int k = 0; k < TO; k++) begin
      step();
      chk("t5_busy_wait", 64'(busy_out), 64'(1));
      chk("t5_to_low",    64'(to_out),   64'(0));
    end
    step();
    chk("t5_busy_abort", 64'(busy_out), 64'(0));
    chk("t5_to_set",     64'(to_out),   64'(1));
    step();
    chk("t5_next_valid", 64'(dv_out),   64'(1));
    chk("t5_next_chan",  64'(chan_out), 64'(4));
    finish_txn(1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_to_clr", 64'(to_out), 64'(0));

    // Reset during wait with channels 4 and 6 pending discards everything
    do_reset();
    set_word(0, 18'h00077); set_word(4, 18'h00044); set_word(6, 18'h00066);
    pulse(8'h01);
    wait_issue("t6_g0", 0, 18'h00077);
    pulse(8'h50);
    step();
    rst_n = 1'b0; step();
    chk("t6_data",  64'(dout_u),   64'(0));
    chk("t6_chan",  64'(chan_out), 64'(0));
    chk("t6_valid", 64'(dv_out),   64'(0));
    chk("t6_busy",  64'(busy_out), 64'(0));
    chk("t6_ovf",   64'(ovf_out),  64'(0));
    chk("t6_to",    64'(to_out),   64'(0));
    rst_n = 1'b1;
    nv = 0;
    repeat (10) begin step(); if (dv_out === 1'b1 || busy_out === 1'b1) nv++; end
    chk("t6_no_grant", 64'(nv), 64'(0));

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dv    = N'($urandom & $urandom);
      act   = ~N'($urandom & $urandom & $urandom);
      done  = ($urandom % 4) == 0;
      clr   = ($urandom % 50) == 0;
      rst_n = ($urandom % 500) != 0;
      for (int ch = 0; ch < N; ch++) set_word(ch, WD'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
